// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: fetch FSM states and fetch constants shared by the fetch unit files
package fetch_unit_pkg;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DRAIN} fetch_state_e;
  localparam logic [31:0] INST_NOP = 32'h0000_0000;
  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: program counter with reset value, load (priority) and step increment
module fetch_pc_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_inc,
  input  logic [31:0] i_load_pc,
  output logic [31:0] o_pc
);
  logic [31:0] r_pc;
  always_ff @(posedge clk)
    r_pc <= rst ? RESET_PC : i_load ? i_load_pc : i_inc ? r_pc + PC_STEP : r_pc;
  assign o_pc = r_pc;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding-request fetch FSM; define FETCH_ALIGN_CHECK_EN to flag misaligned redirect targets
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_out,
  output logic [31:0] pcplus4_out,
  output logic        bubble_out,
  output logic        misalign_out
);
  fetch_state_e r_state, w_next;
  logic [31:0] r_buf, w_pc;
  logic w_fetch, w_hold, w_deliver;
  assign w_fetch = !rst && r_state == S_FETCH;
  assign w_hold = !rst && r_state == S_HOLD;
  assign w_deliver = !redirect && !stall && (w_fetch && imem_ack || w_hold);
  assign imem_req = w_fetch;
  assign imem_addr = w_pc;
  assign bubble_out = !w_deliver;
  assign inst_out = !w_deliver ? INST_NOP : w_hold ? r_buf : imem_rdata;
  assign pcplus4_out = w_deliver ? w_pc + PC_STEP : 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
  assign misalign_out = !rst && redirect && redirect_pc[1:0] != 2'b00;
`else
  assign misalign_out = 1'b0;
`endif
  fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk      (clk),
    .rst      (rst),
    .i_load   (redirect),
    .i_inc    (w_deliver),
    .i_load_pc(redirect_pc & ALIGN_MASK),
    .o_pc     (w_pc)
  );
  // a redirect with the request still in flight must wait out its ack in DRAIN
  always_comb
    w_next = r_state == S_IDLE ? S_FETCH
           : r_state == S_FETCH ? (imem_ack ? (stall && !redirect ? S_HOLD : S_FETCH)
                                            : (redirect ? S_DRAIN : S_FETCH))
           : r_state == S_HOLD ? (stall && !redirect ? S_HOLD : S_FETCH)
           : imem_ack ? S_FETCH : S_DRAIN;
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= S_IDLE;
      r_buf <= INST_NOP;
    end else begin
      r_state <= w_next;
      r_buf <= redirect ? INST_NOP : (w_fetch && imem_ack && stall) ? imem_rdata : r_buf;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed literal checks plus randomized run against a request/ack level model
module tb_fetch_unit;
  localparam logic [31:0] RPC = 32'h0000_0100;
  logic clk = 0, rst = 1, stall = 0, redirect = 0, imem_ack = 0;
  logic [31:0] redirect_pc = 0, imem_rdata = 0;
  logic imem_req, bubble_out, misalign_out;
  logic [31:0] imem_addr, inst_out, pcplus4_out;
  int total = 0, bad = 0;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_out(inst_out), .pcplus4_out(pcplus4_out), .bubble_out(bubble_out), .misalign_out(misalign_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // model: pc, a buffered word awaiting release, an in-flight request to discard, the post-reset idle cycle
  logic [31:0] m_pc = RPC, m_word = 0;
  bit m_hold = 0, m_drop = 0, m_idle = 1;

  initial begin
    @(posedge clk);
    forever begin
      logic e_req, dlv, e_mis;
      @(negedge clk);
      e_req = !rst && !m_idle && !m_hold && !m_drop;
      dlv = !rst && !redirect && !stall && ((e_req && imem_ack) || m_hold);
`ifdef FETCH_ALIGN_CHECK_EN
      e_mis = !rst && redirect && redirect_pc[1:0] != 2'b00;
`else
      e_mis = 1'b0;
`endif
      chk("m_req", {31'b0, imem_req}, {31'b0, e_req});
      if (e_req) chk("m_addr", imem_addr, m_pc);
      chk("m_bubble", {31'b0, bubble_out}, {31'b0, !dlv});
      chk("m_inst", inst_out, !dlv ? 32'h0 : m_hold ? m_word : imem_rdata);
      chk("m_pcp4", pcplus4_out, dlv ? m_pc + 32'd4 : 32'h0);
      chk("m_misalign", {31'b0, misalign_out}, {31'b0, e_mis});
      if (rst) begin
        m_pc = RPC; m_hold = 0; m_drop = 0; m_idle = 1;
      end else if (redirect) begin
        m_pc = {redirect_pc[31:2], 2'b00};
        m_drop = (e_req || m_drop) && !imem_ack;
        m_hold = 0; m_idle = 0;
      end else begin
        if (e_req && imem_ack && stall) begin m_hold = 1; m_word = imem_rdata; end
        else if (dlv) m_hold = 0;
        if (dlv) m_pc = m_pc + 32'd4;
        if (imem_ack) m_drop = 0;
        m_idle = 0;
      end
    end
  end

  task automatic step(input logic r_st, input logic s, input logic rd, input logic [31:0] rp,
                      input logic a, input logic [31:0] d);
    @(posedge clk); #1;
    rst = r_st; stall = s; redirect = rd; redirect_pc = rp; imem_ack = a; imem_rdata = d;
    @(negedge clk);
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  logic exp_mis;
  bit mem_busy = 0;
  int mem_lat = 0;
  logic [31:0] mem_addr = 0;

  initial begin
`ifdef FETCH_ALIGN_CHECK_EN
    exp_mis = 1'b1;
`else
    exp_mis = 1'b0;
`endif
    step(1, 0, 1, 32'h503, 1, 32'h1111_1111);
    chk("rst_req", {31'b0, imem_req}, 0);
    chk("rst_bubble", {31'b0, bubble_out}, 1);
    chk("rst_inst", inst_out, 0);
    chk("rst_pcp4", pcplus4_out, 0);
    chk("rst_misalign", {31'b0, misalign_out}, 0);
    step(0, 0, 0, 0, 1, 32'hDEAD_0001);
    chk("idle_req", {31'b0, imem_req}, 0);
    chk("idle_bubble", {31'b0, bubble_out}, 1);
    step(0, 0, 0, 0, 1, 32'hA000_0000);
    chk("seq0_addr", imem_addr, 32'h100);
    chk("seq0_inst", inst_out, 32'hA000_0000);
    chk("seq0_pcp4", pcplus4_out, 32'h104);
    chk("seq0_bubble", {31'b0, bubble_out}, 0);
    step(0, 0, 0, 0, 1, 32'hA000_0001);
    chk("seq1_addr", imem_addr, 32'h104);
    chk("seq1_pcp4", pcplus4_out, 32'h108);
    step(0, 0, 0, 0, 1, 32'hA000_0002);
    chk("seq2_addr", imem_addr, 32'h108);
    chk("seq2_pcp4", pcplus4_out, 32'h10C);
    step(0, 0, 1, 32'h200, 1, 32'hBAD0_0000);
    chk("redir_ack_bubble", {31'b0, bubble_out}, 1);
    chk("redir_ack_inst", inst_out, 0);
    step(0, 1, 0, 0, 1, 32'hB000_0000);
    chk("stall_addr", imem_addr, 32'h200);
    chk("stall_bubble", {31'b0, bubble_out}, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 0, 32'h0);
      chk("hold_req", {31'b0, imem_req}, 0);
      chk("hold_bubble", {31'b0, bubble_out}, 1);
    end
    step(0, 0, 0, 0, 0, 32'h0);
    chk("release_bubble", {31'b0, bubble_out}, 0);
    chk("release_inst", inst_out, 32'hB000_0000);
    chk("release_pcp4", pcplus4_out, 32'h204);
    step(0, 0, 1, 32'h300, 1, 32'hBAD0_0001);
    step(0, 0, 1, 32'h400, 0, 32'h0);
    chk("pend_addr", imem_addr, 32'h300);
    chk("pend_bubble", {31'b0, bubble_out}, 1);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("drain_req", {31'b0, imem_req}, 0);
    step(0, 0, 0, 0, 1, 32'hBAD0_0300);
    chk("drain_ack_bubble", {31'b0, bubble_out}, 1);
    chk("drain_ack_inst", inst_out, 0);
    step(0, 0, 0, 0, 1, 32'hC000_0000);
    chk("after_drain_addr", imem_addr, 32'h400);
    chk("after_drain_inst", inst_out, 32'hC000_0000);
    step(0, 0, 1, 32'hFFFF_FFFC, 1, 32'hBAD0_0002);
    step(0, 0, 0, 0, 1, 32'hE000_0000);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_pcp4", pcplus4_out, 32'h0);
    step(0, 0, 1, 32'h503, 1, 32'hBAD0_0003);
    chk("wrap_next_addr", imem_addr, 32'h0);
    chk("misalign_pulse", {31'b0, misalign_out}, {31'b0, exp_mis});
    step(0, 0, 0, 0, 0, 32'h0);
    chk("aligned_addr", imem_addr, 32'h500);
    chk("misalign_clear", {31'b0, misalign_out}, 0);
    step(1, 0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 1, 32'hBAD0_0004);
    chk("post_rst_ack_bubble", {31'b0, bubble_out}, 1);
    chk("post_rst_ack_req", {31'b0, imem_req}, 0);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("post_rst_addr", imem_addr, RPC);
    for (int n = 0; n < 4000; n++) begin
      logic req_now;
      logic [31:0] rp;
      @(posedge clk); #1;
      if (imem_ack || rst) mem_busy = 0;
      req_now = imem_req;
      if (req_now && !mem_busy) begin
        mem_busy = 1; mem_addr = imem_addr; mem_lat = $urandom_range(0, 3);
      end
      imem_ack = mem_busy && mem_lat == 0;
      if (mem_busy && mem_lat != 0) mem_lat--;
      imem_rdata = imem_ack ? memf(mem_addr) : $urandom;
      rst = $urandom_range(0, 99) == 0;
      stall = $urandom_range(0, 9) < 3;
      redirect = $urandom_range(0, 9) == 0;
      rp = $urandom;
      if ($urandom_range(0, 7) == 0) rp = 32'hFFFF_FFF0 | {28'b0, rp[3:0]};
      else if ($urandom_range(0, 3) != 0) rp[1:0] = 2'b00;
      redirect_pc = rp;
    end
    @(posedge clk); #1;
    rst = 0; redirect = 0; stall = 0; imem_ack = 0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
